// File: rtl/pad_din_filter.sv
// Per-side pad input conditioner: synchronizes and debounces each pad bit.
// It also produces edge pulses, sticky event flags and a masked interrupt.
module pad_din_filter #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBNC_W      = 8,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  din_i,
  input  logic [DBNC_W-1:0] dbnc_i,
  input  logic [WIDTH-1:0]  rise_en_i,
  input  logic [WIDTH-1:0]  fall_en_i,
  input  logic [WIDTH-1:0]  evt_clr_i,
  input  logic [WIDTH-1:0]  irq_en_i,
  output logic [WIDTH-1:0]  din_o,
  output logic [WIDTH-1:0]  rise_o,
  output logic [WIDTH-1:0]  fall_o,
  output logic [WIDTH-1:0]  evt_o,
  output logic              irq_o
);

  typedef enum logic {ST_STABLE, ST_COUNTING} state_e;

  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  sync_w;
  state_e            state_q [WIDTH];
  state_e            state_d [WIDTH];
  logic [DBNC_W-1:0] cnt_q   [WIDTH];
  logic [DBNC_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0]  din_q, din_d;
  logic [WIDTH-1:0]  rise_q, rise_d;
  logic [WIDTH-1:0]  fall_q, fall_d;
  logic [WIDTH-1:0]  evt_q, evt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VEC;
    end else begin
      sync_q[0] <= din_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Commit uses >= so a threshold lowered mid-count takes effect on the next edge.
  always_comb begin
    din_d  = din_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = ST_STABLE;
      cnt_d[i]   = '0;
      if (sync_w[i] != din_q[i]) begin
        case (state_q[i])
          ST_STABLE: begin
            if (dbnc_i == '0) begin
              din_d[i]  = sync_w[i];
              rise_d[i] = sync_w[i];
              fall_d[i] = ~sync_w[i];
            end else begin
              state_d[i] = ST_COUNTING;
              cnt_d[i]   = DBNC_W'(1);
            end
          end
          ST_COUNTING: begin
            if (cnt_q[i] >= dbnc_i) begin
              din_d[i]  = sync_w[i];
              rise_d[i] = sync_w[i];
              fall_d[i] = ~sync_w[i];
            end else begin
              state_d[i] = ST_COUNTING;
              cnt_d[i]   = cnt_q[i] + DBNC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
    // Set has priority over a simultaneous clear.
    evt_d = (evt_q & ~evt_clr_i) | (rise_d & rise_en_i) | (fall_d & fall_en_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      din_q  <= RST_VEC;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      din_q  <= din_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign din_o  = din_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign evt_o  = evt_q;
  assign irq_o  = |(evt_q & irq_en_i);

endmodule
